multicycle_sequencer: RTL and testbench

Multi-cycle FSM that sequences the single-ported datapath through FETCH/DECODE/EXECUTE/MEMORY/WRITEBACK.
- Consumes the opcode and the MEM/WB flags from the instruction decoder (controller).
- Drives the memory request handshake, IR load, PC update and register-bank write strobe.
- Keeps a retired-instruction counter and a memory-timeout watchdog.

---
 rtl/multicycle_sequencer.sv | 172 +++++++++++++++++
 tb/tb_multicycle_sequencer.sv | 205 ++++++++++++++++++++
 2 files changed

// File: rtl/multicycle_sequencer.sv
// Multi-cycle control sequencer: walks the shared datapath through
// FETCH/DECODE/EXECUTE/MEMORY/WRITEBACK with a memory wait watchdog.
module multicycle_sequencer #(
  parameter int CNT_W       = 32,
  parameter int MEM_TIMEOUT = 15
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             halt_req,
  input  logic [6:0]       op,
  input  logic             mem_write_flag,
  input  logic             wb_lmd_flag,
  input  logic             wb_aluout_flag,
  input  logic             mem_ready,
  output logic             mem_req,
  output logic             mem_we,
  output logic             mem_addr_sel,
  output logic             ir_load,
  output logic             pc_en,
  output logic             regbank_we,
  output logic [2:0]       state,
  output logic             busy,
  output logic [CNT_W-1:0] retired_count,
  output logic             illegal_op
);

  typedef enum logic [2:0] {
    S_IDLE      = 3'd0,
    S_FETCH     = 3'd1,
    S_DECODE    = 3'd2,
    S_EXECUTE   = 3'd3,
    S_MEMORY    = 3'd4,
    S_WRITEBACK = 3'd5,
    S_ERROR     = 3'd7
  } state_t;

  localparam int WAIT_W = $clog2(MEM_TIMEOUT + 1);

  state_t             state_r;
  state_t             next_state_s;
  state_t             retire_target_s;
  logic [WAIT_W-1:0]  wait_cnt_r;
  logic [WAIT_W-1:0]  wait_cnt_next_s;
  logic [CNT_W-1:0]   retired_r;
  logic               illegal_r;
  logic               retire_s;
  logic               ir_load_s;
  logic               set_illegal_s;
  logic               wait_expired_s;
  logic               wb_any_s;
  logic               mem_op_s;

  function automatic logic is_legal_op(input logic [6:0] opcode);
    logic legal;
    case (opcode)
      7'd3, 7'd19, 7'd23, 7'd35, 7'd51, 7'd55, 7'd99, 7'd111: legal = 1'b1;
      default:                                                 legal = 1'b0;
    endcase
    return legal;
  endfunction

  assign wb_any_s        = wb_lmd_flag | wb_aluout_flag;
  assign mem_op_s        = (op == 7'd3) || (op == 7'd35);
  // The wait that would bring the count to MEM_TIMEOUT is the expiring one.
  assign wait_expired_s  = (wait_cnt_r == WAIT_W'(MEM_TIMEOUT - 1));
  assign retire_target_s = halt_req ? S_IDLE : S_FETCH;

  // Next-state, watchdog and Mealy pulse decode
  always_comb begin
    next_state_s    = state_r;
    wait_cnt_next_s = '0;
    ir_load_s       = 1'b0;
    retire_s        = 1'b0;
    set_illegal_s   = 1'b0;
    case (state_r)
      S_IDLE: begin
        if (start) next_state_s = S_FETCH;
        else       next_state_s = S_IDLE;
      end
      S_FETCH: begin
        if (mem_ready) begin
          ir_load_s    = 1'b1;
          next_state_s = S_DECODE;
        end else if (wait_expired_s) begin
          next_state_s = S_ERROR;
        end else begin
          wait_cnt_next_s = wait_cnt_r + WAIT_W'(1);
        end
      end
      S_DECODE: begin
        if (is_legal_op(op)) begin
          next_state_s = S_EXECUTE;
        end else begin
          next_state_s  = S_ERROR;
          set_illegal_s = 1'b1;
        end
      end
      S_EXECUTE: begin
        if (mem_op_s) begin
          next_state_s = S_MEMORY;
        end else if (wb_any_s) begin
          next_state_s = S_WRITEBACK;
        end else begin
          retire_s     = 1'b1;
          next_state_s = retire_target_s;
        end
      end
      S_MEMORY: begin
        if (mem_ready) begin
          if (op == 7'd35) begin
            retire_s     = 1'b1;
            next_state_s = retire_target_s;
          end else begin
            next_state_s = S_WRITEBACK;
          end
        end else if (wait_expired_s) begin
          next_state_s = S_ERROR;
        end else begin
          wait_cnt_next_s = wait_cnt_r + WAIT_W'(1);
        end
      end
      S_WRITEBACK: begin
        retire_s     = 1'b1;
        next_state_s = retire_target_s;
      end
      S_ERROR:  next_state_s = S_ERROR;
      default:  next_state_s = S_ERROR;
    endcase
  end

  // Moore strobes decoded from the current state
  always_comb begin
    mem_req      = 1'b0;
    mem_we       = 1'b0;
    mem_addr_sel = 1'b0;
    regbank_we   = 1'b0;
    case (state_r)
      S_FETCH:     mem_req = 1'b1;
      S_MEMORY: begin
        mem_req      = 1'b1;
        mem_addr_sel = 1'b1;
        mem_we       = mem_write_flag;
      end
      S_WRITEBACK: regbank_we = wb_any_s;
      default:     mem_req = 1'b0;
    endcase
  end

  // State, watchdog, retire counter and sticky illegal flag
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r    <= S_IDLE;
      wait_cnt_r <= '0;
      retired_r  <= '0;
      illegal_r  <= 1'b0;
    end else begin
      state_r    <= next_state_s;
      wait_cnt_r <= wait_cnt_next_s;
      if (retire_s)      retired_r <= retired_r + CNT_W'(1);
      if (set_illegal_s) illegal_r <= 1'b1;
    end
  end

  assign ir_load       = ir_load_s;
  assign pc_en         = retire_s;
  assign state         = state_r;
  assign busy          = (state_r != S_IDLE) && (state_r != S_ERROR);
  assign retired_count = retired_r;
  assign illegal_op    = illegal_r;

endmodule

// File: tb/tb_multicycle_sequencer.sv
// Bench for multicycle_sequencer: instruction table with a retire scoreboard,
// plus directed timeout, illegal-opcode and mid-instruction reset sequences.
module tb_multicycle_sequencer;

  localparam int CNT_W       = 4;
  localparam int MEM_TIMEOUT = 4;

  logic             clk = 1'b0;
  logic             rst_n, start, halt_req, mem_ready;
  logic [6:0]       op;
  logic             mem_write_flag, wb_lmd_flag, wb_aluout_flag;
  logic             mem_req, mem_we, mem_addr_sel, ir_load, pc_en, regbank_we;
  logic [2:0]       state;
  logic             busy, illegal_op;
  logic [CNT_W-1:0] retired_count;

  multicycle_sequencer #(.CNT_W(CNT_W), .MEM_TIMEOUT(MEM_TIMEOUT)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .halt_req(halt_req), .op(op),
    .mem_write_flag(mem_write_flag), .wb_lmd_flag(wb_lmd_flag),
    .wb_aluout_flag(wb_aluout_flag), .mem_ready(mem_ready),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr_sel(mem_addr_sel),
    .ir_load(ir_load), .pc_en(pc_en), .regbank_we(regbank_we), .state(state),
    .busy(busy), .retired_count(retired_count), .illegal_op(illegal_op)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [6:0] op;
    logic       mw, lmd, alu;
    int         fwait, mwait;      // not-ready cycles before the handshake
    int         exp_cycles;        // FETCH entry to retire, inclusive
    int         exp_state;         // state seen in the retire cycle
    int         exp_wb, exp_we, exp_req;
  } vec_t;

  vec_t             tbl[10];
  vec_t             exp_q[$];
  int               checks = 0;
  int               errors = 0;
  logic [CNT_W-1:0] exp_cnt;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: actual=%0d required=%0d", name, act, exp);
    end
  endtask

  function automatic logic ready_at(input vec_t v, input int k);
    int ms;
    ms = v.fwait + 3;
    if (k < v.fwait)                          return 1'b0;
    else if (k >= ms && k < ms + v.mwait)     return 1'b0;
    else                                      return 1'b1;
  endfunction

  task automatic go();
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    chk("fetch_entry", 32'(state), 32'd1);
  endtask

  task automatic release_reset();
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;
  endtask

  // Runs one instruction from FETCH; the retire cycle pops the scoreboard.
  task automatic run_vec(input vec_t v, input logic halt, input logic st);
    int   k, nwb, nwe, nreq, nir;
    logic done;
    vec_t e;
    exp_q.push_back(v);
    op = v.op; mem_write_flag = v.mw; wb_lmd_flag = v.lmd; wb_aluout_flag = v.alu;
    halt_req = halt; start = st;
    k = 0; done = 1'b0; nwb = 0; nwe = 0; nreq = 0; nir = 0;
    while (!done && k < 40) begin
      mem_ready = ready_at(v, k);
      @(negedge clk);
      if (mem_req)    nreq++;
      if (mem_we)     nwe++;
      if (regbank_we) nwb++;
      if (ir_load)    nir++;
      if (pc_en) begin
        done = 1'b1;
        e = exp_q.pop_front();
        chk("retire_cycle", 32'(k + 1), 32'(e.exp_cycles));
        chk("retire_state", 32'(state), 32'(e.exp_state));
        chk("regbank_we_cycles", 32'(nwb), 32'(e.exp_wb));
        chk("mem_we_cycles", 32'(nwe), 32'(e.exp_we));
        chk("mem_req_cycles", 32'(nreq), 32'(e.exp_req));
        chk("ir_load_pulses", 32'(nir), 32'd1);
      end
      @(posedge clk); #1;
      k++;
    end
    if (!done) begin
      checks++; errors++;
      $display("FAIL retire_timeout: op=%0d never retired within 40 cycles", v.op);
      void'(exp_q.pop_front());
    end
    exp_cnt = exp_cnt + 1'b1;
    chk("retired_count", 32'(retired_count), 32'(exp_cnt));
    chk("post_retire_state", 32'(state), halt ? 32'd0 : 32'd1);
    halt_req = 1'b0; start = 1'b0;
  endtask

  initial begin
    //         op      mw    lmd   alu   fw mw cyc st wb we req
    tbl[0] = '{7'd51,  1'b0, 1'b0, 1'b1, 0, 0, 4, 5, 1, 0, 1};
    tbl[1] = '{7'd3,   1'b0, 1'b1, 1'b0, 0, 3, 8, 5, 1, 0, 5};
    tbl[2] = '{7'd35,  1'b1, 1'b0, 1'b0, 0, 0, 4, 4, 0, 1, 2};
    tbl[3] = '{7'd99,  1'b0, 1'b0, 1'b0, 0, 0, 3, 3, 0, 0, 1};
    tbl[4] = '{7'd19,  1'b0, 1'b0, 1'b1, 2, 0, 6, 5, 1, 0, 3};
    tbl[5] = '{7'd55,  1'b0, 1'b0, 1'b1, 0, 0, 4, 5, 1, 0, 1};
    tbl[6] = '{7'd111, 1'b0, 1'b0, 1'b1, 0, 0, 4, 5, 1, 0, 1};
    tbl[7] = '{7'd23,  1'b0, 1'b0, 1'b1, 3, 0, 7, 5, 1, 0, 4};
    tbl[8] = '{7'd35,  1'b1, 1'b0, 1'b0, 1, 2, 7, 4, 0, 3, 5};
    tbl[9] = '{7'd55,  1'b0, 1'b1, 1'b0, 0, 0, 4, 5, 1, 0, 1};

    rst_n = 1'b0; start = 1'b0; halt_req = 1'b0; mem_ready = 1'b0; op = 7'd0;
    mem_write_flag = 1'b0; wb_lmd_flag = 1'b0; wb_aluout_flag = 1'b0;
    #12;
    chk("rst_state", 32'(state), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_strobes", 32'({mem_req, mem_we, ir_load, pc_en, regbank_we}), 32'd0);
    chk("rst_count", 32'(retired_count), 32'd0);
    chk("rst_illegal", 32'(illegal_op), 32'd0);
    release_reset();
    chk("idle_hold", 32'(state), 32'd0);

    // Two passes: 20 retires wrap the 4-bit counter; last one halts.
    exp_cnt = '0;
    go();
    for (int p = 0; p < 2; p++)
      for (int i = 0; i < 10; i++)
        run_vec(tbl[i], (p == 1 && i == 9), (p == 1));
    chk("halt_busy", 32'(busy), 32'd0);

    // Fetch watchdog: four not-ready cycles then ERROR.
    go();
    mem_ready = 1'b0;
    for (int k = 0; k < MEM_TIMEOUT; k++) begin
      @(negedge clk);
      chk("timeout_fetch_wait", 32'({state, mem_req}), 32'({3'd1, 1'b1}));
      @(posedge clk); #1;
    end
    chk("timeout_error_state", 32'(state), 32'd7);
    chk("timeout_outputs", 32'({busy, mem_req, illegal_op}), 32'd0);
    start = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    start = 1'b0;
    chk("error_ignores_start", 32'(state), 32'd7);
    chk("error_keeps_count", 32'(retired_count), 32'(exp_cnt));
    rst_n = 1'b0; #1;
    chk("timeout_reset_state", 32'(state), 32'd0);
    chk("timeout_reset_count", 32'(retired_count), 32'd0);
    release_reset();

    // Illegal opcode: DECODE then sticky ERROR until reset.
    go();
    op = 7'h7F; mem_write_flag = 1'b0; wb_lmd_flag = 1'b0; wb_aluout_flag = 1'b0;
    mem_ready = 1'b1;
    @(posedge clk); #1;
    chk("illegal_decode", 32'(state), 32'd2);
    @(posedge clk); #1;
    chk("illegal_error", 32'({state, illegal_op, busy}), 32'({3'd7, 1'b1, 1'b0}));
    start = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    start = 1'b0;
    chk("illegal_sticky", 32'({state, illegal_op}), 32'({3'd7, 1'b1}));
    rst_n = 1'b0; #1;
    chk("illegal_reset", 32'({state, illegal_op}), 32'd0);
    release_reset();

    // Reset while MEMORY is waiting abandons the load at once.
    go();
    op = 7'd3; wb_lmd_flag = 1'b1; mem_ready = 1'b1;
    @(posedge clk); #1;
    mem_ready = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("mid_mem_state", 32'({state, mem_req, mem_addr_sel, mem_we}), 32'({3'd4, 3'b110}));
    rst_n = 1'b0; #1;
    chk("mid_mem_reset", 32'({state, mem_req, busy, regbank_we, pc_en}), 32'd0);
    release_reset();
    chk("mid_mem_idle", 32'(state), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not complete");
    $fatal(1);
  end

endmodule
